// File: rtl/spi_master_ctrl.sv
// SPI mode-0 burst transaction engine.
// Takes a launch request from the control register, runs n_tx_end+1 byte transfers
// using TX buffer bytes, stores the received bytes in the RX buffer, and writes
// progress/completion status back into the control register.
module spi_master_ctrl #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned HALF_PERIOD = 2,
    parameter int unsigned ADDR_WIDTH  = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] ctrl_i,
    input  logic [7:0]            tx_data_i,
    output logic [ADDR_WIDTH-1:0] tx_addr_o,
    output logic [7:0]            rx_data_o,
    output logic [ADDR_WIDTH-1:0] rx_addr_o,
    output logic                  rx_wr_o,
    output logic                  ctrl_wr_o,
    output logic                  send_clear_o,
    output logic [9:0]            n_rx_end_o,
    output logic                  busy_o,
    output logic                  sclk_o,
    output logic                  cs_o,
    output logic                  mosi_o,
    input  logic                  miso_i
);

    localparam int unsigned CntW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFetch,
        StShift,
        StStore,
        StGap,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] n_tx_end_q, n_tx_end_d;
    logic                  cs_ctrl_q, cs_ctrl_d;
    logic                  all_1s_q, all_1s_d;
    logic                  all_0s_q, all_0s_d;
    logic [7:0]            tx_sr_q, tx_sr_d;
    logic [7:0]            rx_sr_q, rx_sr_d;
    logic [2:0]            bit_q, bit_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  phase_q, phase_d;

    logic [7:0]            fetch_byte;
    logic                  last_byte;
    logic                  unused_ctrl;

    // all_1s wins over all_0s; otherwise the buffer byte is sent.
    assign fetch_byte  = all_1s_q ? 8'hFF : (all_0s_q ? 8'h00 : tx_data_i);
    assign last_byte   = (idx_q == n_tx_end_q);
    assign tx_addr_o   = idx_q;
    assign rx_addr_o   = idx_q;
    assign rx_data_o   = rx_sr_q;
    // n_rx_end and reserved fields are written by this block, never read.
    assign unused_ctrl = ^ctrl_i[DATA_WIDTH-1:13];

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            n_tx_end_q <= '0;
            cs_ctrl_q  <= 1'b0;
            all_1s_q   <= 1'b0;
            all_0s_q   <= 1'b0;
            tx_sr_q    <= 8'h00;
            rx_sr_q    <= 8'h00;
            bit_q      <= 3'd0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            n_tx_end_q <= n_tx_end_d;
            cs_ctrl_q  <= cs_ctrl_d;
            all_1s_q   <= all_1s_d;
            all_0s_q   <= all_0s_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            bit_q      <= bit_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
        end
    end

    // Next-state logic and per-state outputs.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        n_tx_end_d   = n_tx_end_q;
        cs_ctrl_d    = cs_ctrl_q;
        all_1s_d     = all_1s_q;
        all_0s_d     = all_0s_q;
        tx_sr_d      = tx_sr_q;
        rx_sr_d      = rx_sr_q;
        bit_d        = bit_q;
        cnt_d        = cnt_q;
        phase_d      = phase_q;

        sclk_o       = 1'b0;
        cs_o         = 1'b1;
        mosi_o       = 1'b0;
        busy_o       = 1'b0;
        rx_wr_o      = 1'b0;
        ctrl_wr_o    = 1'b0;
        send_clear_o = 1'b0;
        n_rx_end_o   = 10'd0;

        case (state_q)
            StIdle: begin
                // Gate on rst_i so no control write leaks out while reset is held.
                if (rst_i && ctrl_i[0]) begin
                    n_tx_end_d   = ADDR_WIDTH'(ctrl_i[12:4]);
                    cs_ctrl_d    = ctrl_i[1];
                    all_1s_d     = ctrl_i[2];
                    all_0s_d     = ctrl_i[3];
                    idx_d        = '0;
                    ctrl_wr_o    = 1'b1;
                    send_clear_o = 1'b1;
                    state_d      = StLoad;
                end
            end

            StLoad: begin
                busy_o  = 1'b1;
                // Chip select first drops at FETCH of byte 0; later bytes keep it low here.
                cs_o    = (idx_q == '0);
                state_d = StFetch;
            end

            StFetch: begin
                busy_o  = 1'b1;
                cs_o    = 1'b0;
                mosi_o  = fetch_byte[7];
                tx_sr_d = fetch_byte;
                bit_d   = 3'd0;
                cnt_d   = '0;
                phase_d = 1'b0;
                state_d = StShift;
            end

            StShift: begin
                busy_o = 1'b1;
                cs_o   = 1'b0;
                sclk_o = phase_q;
                mosi_o = tx_sr_q[7];
                // Sample on the first cycle of the high phase.
                if (phase_q && (cnt_q == '0)) begin
                    rx_sr_d = {rx_sr_q[6:0], miso_i};
                end
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q == 3'd7) begin
                            state_d = StStore;
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            tx_sr_d = {tx_sr_q[6:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StStore: begin
                busy_o       = 1'b1;
                cs_o         = 1'b0;
                rx_wr_o      = 1'b1;
                ctrl_wr_o    = 1'b1;
                n_rx_end_o   = 10'(idx_q) + 10'd1;
                send_clear_o = ~last_byte;
                cnt_d        = '0;
                if (last_byte) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = cs_ctrl_q ? StLoad : StGap;
                end
            end

            StGap: begin
                busy_o = 1'b1;
                cs_o   = 1'b1;
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StLoad;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: stimulus pushes expected RX-buffer and
// control-register writes; a negedge monitor pops and compares on each pulse.
module tb_spi_master_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] ctrl_i;
    logic [7:0]  tx_data_i;
    logic [8:0]  tx_addr_o;
    logic [7:0]  rx_data_o;
    logic [8:0]  rx_addr_o;
    logic        rx_wr_o;
    logic        ctrl_wr_o;
    logic        send_clear_o;
    logic [9:0]  n_rx_end_o;
    logic        busy_o;
    logic        sclk_o;
    logic        cs_o;
    logic        mosi_o;
    logic        miso_i;

    always #5 clk = ~clk;

    spi_master_ctrl #(
        .DATA_WIDTH (32),
        .HALF_PERIOD(2),
        .ADDR_WIDTH (9)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .ctrl_i      (ctrl_i),
        .tx_data_i   (tx_data_i),
        .tx_addr_o   (tx_addr_o),
        .rx_data_o   (rx_data_o),
        .rx_addr_o   (rx_addr_o),
        .rx_wr_o     (rx_wr_o),
        .ctrl_wr_o   (ctrl_wr_o),
        .send_clear_o(send_clear_o),
        .n_rx_end_o  (n_rx_end_o),
        .busy_o      (busy_o),
        .sclk_o      (sclk_o),
        .cs_o        (cs_o),
        .mosi_o      (mosi_o),
        .miso_i      (miso_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // TX buffer: synchronous read, data one cycle after the address.
    logic [7:0] tx_mem [512];
    always @(posedge clk) tx_data_i <= tx_mem[tx_addr_o];

    // Slave: loopback or a fixed response byte, MSB first, advancing on SCLK fall.
    logic       loop_mode;
    logic [7:0] slave_byte;
    int         slave_idx;
    logic       slave_bit;
    always_comb begin
        slave_bit = 1'b0;
        if (slave_idx < 8) slave_bit = slave_byte[3'(7 - slave_idx)];
    end
    assign miso_i = loop_mode ? mosi_o : slave_bit;

    logic [10:0] exp_ctrl_q[$];  // {send_clear, n_rx_end}
    logic [16:0] exp_rx_q[$];    // {addr, data}
    logic [10:0] mon_ctrl_e;
    logic [16:0] mon_rx_e;

    logic       sclk_prev = 1'b0;
    int         rise_cnt;
    logic [7:0] mosi_byte;
    int         gap_cnt, gap_min, gap_max, hi_run;
    bit         seen_low;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops plus SCLK/MOSI/CS observation.
    always @(negedge clk) begin
        if (rx_wr_o) begin
            if (exp_rx_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rx_wr: addr 0x%0h data 0x%0h, expected no write",
                         rx_addr_o, rx_data_o);
            end else begin
                mon_rx_e = exp_rx_q.pop_front();
                check("rx_addr", 32'(rx_addr_o), 32'(mon_rx_e[16:8]));
                check("rx_data", 32'(rx_data_o), 32'(mon_rx_e[7:0]));
            end
        end
        if (ctrl_wr_o) begin
            if (exp_ctrl_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ctrl_wr: n_rx_end %0d send %0d, expected no write",
                         n_rx_end_o, send_clear_o);
            end else begin
                mon_ctrl_e = exp_ctrl_q.pop_front();
                check("ctrl_n_rx_end", 32'(n_rx_end_o), 32'(mon_ctrl_e[9:0]));
                check("ctrl_send", 32'(send_clear_o), 32'(mon_ctrl_e[10]));
            end
        end
        if (sclk_o && !sclk_prev) begin
            rise_cnt++;
            mosi_byte = {mosi_byte[6:0], mosi_o};
        end
        if (!sclk_o && sclk_prev) slave_idx++;
        if (rx_wr_o) slave_idx = 0;
        sclk_prev = sclk_o;
        if (busy_o && cs_o) begin
            hi_run++;
        end else if (!cs_o) begin
            if (hi_run > 0 && seen_low) begin
                gap_cnt++;
                if (hi_run < gap_min) gap_min = hi_run;
                if (hi_run > gap_max) gap_max = hi_run;
            end
            hi_run   = 0;
            seen_low = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_obs();
        rise_cnt  = 0;
        mosi_byte = 8'h00;
        slave_idx = 0;
        gap_cnt   = 0;
        gap_min   = 1000;
        gap_max   = 0;
        hi_run    = 0;
        seen_low  = 1'b0;
    endtask

    // Launch one burst, scribble ctrl_i during it, and wait for busy to drop.
    task automatic run_burst(input logic [31:0] word, input int n_bytes, output int busy_cyc);
        exp_ctrl_q.push_back({1'b1, 10'd0});
        for (int i = 0; i < n_bytes; i++) begin
            exp_ctrl_q.push_back({(i == n_bytes - 1) ? 1'b0 : 1'b1, 10'(i + 1)});
        end
        reset_obs();
        ctrl_i = word | 32'h1;
        tick();
        ctrl_i   = (word ^ 32'h007F_FFFE) & ~32'h1;
        busy_cyc = 0;
        for (int k = 0; k < 5000; k++) begin
            tick();
            busy_cyc++;
            if (!busy_o) break;
        end
        check("burst_completes", 32'(busy_o), 32'd0);
        ctrl_i = word & ~32'h1;
        tick();
        tick();
    endtask

    int cyc;
    int busy_cnt;

    initial begin
        for (int i = 0; i < 512; i++) tx_mem[i] = 8'h00;
        rst_i      = 1'b0;
        ctrl_i     = 32'h0;
        loop_mode  = 1'b1;
        slave_byte = 8'h00;
        reset_obs();

        // Reset state
        tick();
        tick();
        tick();
        check("rst_sclk", 32'(sclk_o), 32'd0);
        check("rst_cs", 32'(cs_o), 32'd1);
        check("rst_mosi", 32'(mosi_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_rx_wr", 32'(rx_wr_o), 32'd0);
        check("rst_ctrl_wr", 32'(ctrl_wr_o), 32'd0);
        check("rst_send_clear", 32'(send_clear_o), 32'd0);
        check("rst_n_rx_end", 32'(n_rx_end_o), 32'd0);
        check("rst_tx_addr", 32'(tx_addr_o), 32'd0);
        check("rst_rx_addr", 32'(rx_addr_o), 32'd0);
        check("rst_rx_data", 32'(rx_data_o), 32'd0);
        rst_i = 1'b1;
        tick();

        // Single transfer: send 0xA5, slave answers 0x3C
        tx_mem[0]  = 8'hA5;
        loop_mode  = 1'b0;
        slave_byte = 8'h3C;
        exp_rx_q.push_back({9'd0, 8'h3C});
        run_burst(32'h0000_0000, 1, cyc);
        check("single_mosi_bits", 32'(mosi_byte), 32'hA5);
        check("single_sclk_rises", 32'(rise_cnt), 32'd8);
        n_tests++;
        if (cyc < 34 || cyc > 36) begin
            n_fail++;
            $display("FAIL single_busy_cycles: got %0d, expected 34..36", cyc);
        end

        // Burst of 4 with CS gaps, loopback
        for (int i = 0; i < 4; i++) begin
            tx_mem[i] = 8'(i + 1);
            exp_rx_q.push_back({9'(i), 8'(i + 1)});
        end
        loop_mode = 1'b1;
        run_burst(32'h0000_0030, 4, cyc);
        check("burst4_sclk_rises", 32'(rise_cnt), 32'd32);
        check("burst4_gap_count", 32'(gap_cnt), 32'd3);
        check("burst4_gap_min", 32'(gap_min), 32'd2);
        check("burst4_gap_max", 32'(gap_max), 32'd2);

        // cs_ctrl=1, 3 bytes: CS held low throughout
        tx_mem[0] = 8'h5A;
        tx_mem[1] = 8'hC3;
        tx_mem[2] = 8'h7E;
        exp_rx_q.push_back({9'd0, 8'h5A});
        exp_rx_q.push_back({9'd1, 8'hC3});
        exp_rx_q.push_back({9'd2, 8'h7E});
        run_burst(32'h0000_0022, 3, cyc);
        check("csctrl_sclk_rises", 32'(rise_cnt), 32'd24);
        check("csctrl_gap_count", 32'(gap_cnt), 32'd0);

        // all_1s and all_0s together: all_1s wins
        tx_mem[0] = 8'h00;
        exp_rx_q.push_back({9'd0, 8'hFF});
        run_burst(32'h0000_000C, 1, cyc);
        check("all1s_mosi_bits", 32'(mosi_byte), 32'hFF);
        check("all1s_sclk_rises", 32'(rise_cnt), 32'd8);

        // No retrigger while send stays low, then relaunch
        ctrl_i   = 32'h0;
        busy_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (busy_o) busy_cnt++;
        end
        check("idle_no_retrigger", 32'(busy_cnt), 32'd0);
        tx_mem[0] = 8'h96;
        exp_rx_q.push_back({9'd0, 8'h96});
        run_burst(32'h0000_0000, 1, cyc);
        check("relaunch_mosi_bits", 32'(mosi_byte), 32'h96);

        // Reset in the middle of byte 2 of a 4-byte burst
        for (int i = 0; i < 4; i++) tx_mem[i] = 8'(i + 1);
        exp_ctrl_q.push_back({1'b1, 10'd0});
        exp_ctrl_q.push_back({1'b1, 10'd1});
        exp_rx_q.push_back({9'd0, 8'h01});
        reset_obs();
        ctrl_i = 32'h0000_0031;
        tick();
        ctrl_i = 32'h0000_0030;
        for (int k = 0; k < 2000; k++) begin
            tick();
            if (rise_cnt >= 11) break;
        end
        check("midreset_reached_byte2", 32'(rise_cnt >= 11), 32'd1);
        rst_i = 1'b0;
        tick();
        check("midreset_cs", 32'(cs_o), 32'd1);
        check("midreset_sclk", 32'(sclk_o), 32'd0);
        check("midreset_busy", 32'(busy_o), 32'd0);
        check("midreset_mosi", 32'(mosi_o), 32'd0);
        check("midreset_rx_data", 32'(rx_data_o), 32'd0);
        check("midreset_tx_addr", 32'(tx_addr_o), 32'd0);
        tick();
        rst_i  = 1'b1;
        ctrl_i = 32'h0;
        busy_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (busy_o) busy_cnt++;
        end
        check("midreset_stays_idle", 32'(busy_cnt), 32'd0);

        check("ctrl_queue_drained", 32'(exp_ctrl_q.size()), 32'd0);
        check("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Transaction engine directly downstream of the SPI control register. It consumes the 32-bit control word and runs a burst of 8-bit SPI mode-0 (CPOL=0, CPHA=0) transfers.
- TX bytes are read from the TX buffer; RX bytes are written to the RX buffer.
- It writes status back into the control register through the second write port: the send clear value and the completed-transfer count.

Control word layout (decided):
- [0] send
- [1] cs_ctrl
- [2] all_1s
- [3] all_0s
- [12:4] n_tx_end (number of transfers minus 1)
- [22:13] n_rx_end
- [31:23] reserved

Parameters:
- DATA_WIDTH, 32, control word width.
- HALF_PERIOD, 2, clk_i cycles per SCLK half-period, minimum 1. The default gives SCLK = 2.5 MHz from a 10 MHz clk_i.
- ADDR_WIDTH, 9, TX/RX buffer address width.

Ports:
- clk_i  in  1  system clock, 10 MHz
- rst_i  in  1  synchronous reset, active low
- ctrl_i  in  DATA_WIDTH  control word from the control register
- tx_data_i  in  8  TX buffer read data, valid 1 cycle after tx_addr_o
- tx_addr_o  out  ADDR_WIDTH  TX buffer read address
- rx_data_o  out  8  received byte
- rx_addr_o  out  ADDR_WIDTH  RX buffer write address
- rx_wr_o  out  1  RX buffer write enable, 1-cycle pulse
- ctrl_wr_o  out  1  write enable into the control register's FSM port
- send_clear_o  out  1  value to write into the send bit
- n_rx_end_o  out  10  value to write into n_rx_end
- busy_o  out  1  burst in progress
- sclk_o  out  1  SPI clock
- cs_o  out  1  chip select, active low
- mosi_o  out  1  serial data out, MSB first
- miso_i  in  1  serial data in

Behaviour:
Reset (rst_i=0 at a clk_i edge), including mid-burst:
- State → IDLE; byte counter idx=0; bit counter=0.
- Outputs: sclk_o=0, cs_o=1, mosi_o=0, busy_o=0, rx_wr_o=0, ctrl_wr_o=0, send_clear_o=0, n_rx_end_o=0, tx_addr_o=0, rx_addr_o=0, rx_data_o=0.
- Partially shifted data is discarded. No control-register write is issued.

States: IDLE, LOAD, FETCH, SHIFT, STORE, GAP, DONE.

IDLE:
- cs_o=1, sclk_o=0, busy_o=0.
- If ctrl_i[0]=1: latch n_tx_end, cs_ctrl, all_1s, all_0s; set idx=0; pulse ctrl_wr_o with n_rx_end_o=0, send_clear_o=1; go to LOAD.

LOAD:
- tx_addr_o=idx; busy_o=1. Next cycle → FETCH.

FETCH:
- Load the shift register: 0xFF if all_1s; else 0x00 if all_0s; else tx_data_i. all_1s has priority.
- cs_o=0; mosi_o=bit 7. → SHIFT.

SHIFT (8 bits):
- Each bit is HALF_PERIOD cycles with sclk_o=0, then HALF_PERIOD cycles with sclk_o=1.
- miso_i is sampled into the RX shift register on the cycle sclk_o rises.
- mosi_o advances to the next bit on the falling edge.
- After bit 0's high phase, sclk_o returns to 0 → STORE.
- One byte takes 16*HALF_PERIOD cycles in SHIFT.

STORE (1 cycle):
- rx_wr_o=1, rx_addr_o=idx, rx_data_o=received byte.
- ctrl_wr_o=1, n_rx_end_o=idx+1.
- send_clear_o=0 if idx==n_tx_end, else 1.
- Transition: if last → DONE; else idx+1 → GAP if cs_ctrl=0, else LOAD.

GAP:
- cs_o=1 for HALF_PERIOD cycles → LOAD.
- With cs_ctrl=1, cs_o stays 0 for the whole burst.

DONE:
- cs_o=1, busy_o=0 for 1 cycle → IDLE.
- send is already 0 in ctrl_i, so there is no retrigger.

Boundary conditions:
- n_tx_end=0 gives 1 transfer.
- n_tx_end=511 gives 512 transfers; n_rx_end_o reaches 512 (10 bits, no overflow).
- ctrl_i changes during a burst are ignored, because fields are latched in IDLE.
- ctrl_wr_o is asserted only in the IDLE launch cycle and in STORE.

Test Plan:
- Reset mid-SHIFT of byte 2 → next cycle: cs_o=1, sclk_o=0, busy_o=0; no further rx_wr_o or ctrl_wr_o pulses.
- Single transfer (n_tx_end=0, tx buffer[0]=0xA5, slave returns 0x3C, HALF_PERIOD=2):
  - mosi_o bits are 1,0,1,0,0,1,0,1.
  - Exactly 8 sclk_o rising edges.
  - rx buffer[0]=0x3C.
  - Final ctrl write is n_rx_end_o=1, send_clear_o=0.
  - busy_o returns low 34–36 cycles after launch.
- Burst of 4 (n_tx_end=3, cs_ctrl=0, tx buffer = 0x01, 0x02, 0x03, 0x04, loopback miso_i=mosi_o):
  - rx buffer = 0x01..0x04.
  - cs_o goes high between bytes for 2 cycles.
  - ctrl writes carry n_rx_end = 0, 1, 2, 3, 4 with send = 1, 1, 1, 1, 0.
- cs_ctrl=1, n_tx_end=2 → cs_o stays low continuously from the first FETCH to DONE.
- all_1s=1 and all_0s=1 together, tx buffer=0x00 → mosi_o=1 for every bit (all_1s priority).
- After DONE, hold ctrl_i[0]=0 for 20 cycles → no new burst. Then set send=1 → a new burst starts, with a launch ctrl write of n_rx_end_o=0.
